// File: rtl/av2_mv_decoder_real.sv
// ---------------------------------------------------------------------------
// av2_mv_decoder_real
//   Motion-vector syntax decoder for the AV2 inter path. The block takes
//   entropy-decoded binary symbols over a valid/ready stream and rebuilds one
//   signed MV pair, x first and then y. It presents the pair on a valid/ready
//   output and pulses done once the pair has been accepted.
//
//   Per component the symbol grammar is:
//     nonzero flag -> sign (1 = positive) -> unary magnitude continuation
//
//   Ports
//     clk             in   1   clock; all state changes on the rising edge
//     rst_n           in   1   asynchronous active-low reset
//     context_idx     in   16  forwarded to the symbol decoder; not used here
//     context_prob    in   16  forwarded to the symbol decoder; not used here
//     decoded_symbol  in   16  current symbol; only bit 0 carries information
//     symbol_valid    in   1   decoded_symbol is valid
//     symbol_ready    out  1   a symbol is consumed this cycle if valid
//     mv_x / mv_y     out  16  signed decoded MV components
//     mv_valid        out  1   mv_x / mv_y hold a complete pair
//     mv_ready        in   1   downstream accepts the MV pair
//     start           in   1   begin one MV pair; only sampled in IDLE
//     done            out  1   one-cycle pulse after the pair is accepted
//
//   Build option
//     AV2_MV_SAT_EN : when defined, each finalized component is clamped to
//                     [-MV_LIMIT, +MV_LIMIT]. When undefined, the value
//                     wraps to 16 bits.
// ---------------------------------------------------------------------------
module av2_mv_decoder_real #(
  parameter int MAX_UNARY = 15,
  parameter int MV_SHIFT  = 0,
  parameter int MV_LIMIT  = 16383
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] context_idx,
  input  logic [15:0] context_prob,
  input  logic [15:0] decoded_symbol,
  input  logic        symbol_valid,
  output logic        symbol_ready,
  output logic [15:0] mv_x,
  output logic [15:0] mv_y,
  output logic        mv_valid,
  input  logic        mv_ready,
  input  logic        start,
  output logic        done
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_X_NZ   = 4'd1;
  localparam logic [3:0] S_X_SIGN = 4'd2;
  localparam logic [3:0] S_X_MAG  = 4'd3;
  localparam logic [3:0] S_Y_NZ   = 4'd4;
  localparam logic [3:0] S_Y_SIGN = 4'd5;
  localparam logic [3:0] S_Y_MAG  = 4'd6;
  localparam logic [3:0] S_OUT    = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  // The magnitude cap: a component never exceeds MAX_UNARY+1 before scaling.
  localparam logic [15:0] MAG_CAP = 16'(MAX_UNARY + 1);

  logic [3:0]  state_q,    state_d;
  logic [15:0] count_q,    count_d;
  logic        sign_q,     sign_d;
  logic [15:0] mv_x_q,     mv_x_d;
  logic [15:0] mv_y_q,     mv_y_d;
  logic        mv_valid_q;
  logic        done_q;

  logic        consume_s;
  logic        sym_s;
  logic [15:0] cnt_inc_s;
  logic        unused_ok;

  // The context inputs and the upper symbol bits belong to the upstream
  // symbol decoder. They are folded here so that they are visibly unused.
  assign unused_ok = ^{context_idx, context_prob, decoded_symbol[15:1], 32'(MV_LIMIT)};

  // Scale the magnitude, apply the sign, and optionally clamp it.
  // The result is a 16-bit two's complement value.
  function automatic logic [15:0] finalize_mv(input logic [15:0] cnt, input logic pos);
    logic [15:0]        mag;
    logic signed [31:0] val;
    mag = cnt << MV_SHIFT;
    if (pos) begin
      val = $signed({16'd0, mag});
    end else begin
      val = -$signed({16'd0, mag});
    end
`ifdef AV2_MV_SAT_EN
    if (val > MV_LIMIT) begin
      val = MV_LIMIT;
    end else if (val < -MV_LIMIT) begin
      val = -MV_LIMIT;
    end else begin
      val = val;
    end
`endif
    return val[15:0];
  endfunction

  // symbol_ready depends only on the current state, so no combinational
  // path exists from symbol_valid to symbol_ready.
  assign symbol_ready = (state_q == S_X_NZ)  || (state_q == S_X_SIGN) ||
                        (state_q == S_X_MAG) || (state_q == S_Y_NZ)   ||
                        (state_q == S_Y_SIGN) || (state_q == S_Y_MAG);

  assign consume_s = symbol_valid && symbol_ready;
  assign sym_s     = decoded_symbol[0];
  assign cnt_inc_s = count_q + 16'd1;

  // Next-state and next-field logic for the MV syntax walk.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sign_d  = sign_q;
    mv_x_d  = mv_x_q;
    mv_y_d  = mv_y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // A new pair starts from zero in both components.
          state_d = S_X_NZ;
          count_d = 16'd0;
          mv_x_d  = 16'd0;
          mv_y_d  = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_X_NZ, S_Y_NZ: begin
        if (consume_s) begin
          if (sym_s) begin
            count_d = 16'd1;
            state_d = (state_q == S_X_NZ) ? S_X_SIGN : S_Y_SIGN;
          end else if (state_q == S_X_NZ) begin
            mv_x_d  = 16'd0;
            state_d = S_Y_NZ;
          end else begin
            mv_y_d  = 16'd0;
            state_d = S_OUT;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_X_SIGN, S_Y_SIGN: begin
        if (consume_s) begin
          sign_d  = sym_s;
          state_d = (state_q == S_X_SIGN) ? S_X_MAG : S_Y_MAG;
        end else begin
          state_d = state_q;
        end
      end
      S_X_MAG, S_Y_MAG: begin
        if (consume_s) begin
          if (sym_s && (cnt_inc_s < MAG_CAP)) begin
            count_d = cnt_inc_s;
          end else if (state_q == S_X_MAG) begin
            // A '1' that reaches the cap is counted and then terminates the run.
            mv_x_d  = finalize_mv(sym_s ? cnt_inc_s : count_q, sign_q);
            state_d = S_Y_NZ;
          end else begin
            mv_y_d  = finalize_mv(sym_s ? cnt_inc_s : count_q, sign_q);
            state_d = S_OUT;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_OUT: begin
        if (mv_ready) begin
          state_d = S_DONE;
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, field, and output registers. mv_valid and done are registered
  // from the next state, so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= 16'd0;
      sign_q     <= 1'b0;
      mv_x_q     <= 16'd0;
      mv_y_q     <= 16'd0;
      mv_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sign_q     <= sign_d;
      mv_x_q     <= mv_x_d;
      mv_y_q     <= mv_y_d;
      mv_valid_q <= (state_d == S_OUT);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign mv_x     = mv_x_q;
  assign mv_y     = mv_y_q;
  assign mv_valid = mv_valid_q;
  assign done     = done_q;

endmodule

// File: tb/tb_av2_mv_decoder_real.sv
// ---------------------------------------------------------------------------
// tb_av2_mv_decoder_real
//   Table-driven bench for av2_mv_decoder_real with the default parameters.
//   Each record holds a symbol string, the expected (x, y) pair, an optional
//   symbol-stall position, and an optional output back-pressure length.
//   The expected pair is queued when a vector starts and is popped when the
//   DUT presents mv_valid. Reset behaviour is exercised by a hand-written
//   sequence.
// ---------------------------------------------------------------------------
module tb_av2_mv_decoder_real;

  logic        clk;
  logic        rst_n;
  logic [15:0] context_idx;
  logic [15:0] context_prob;
  logic [15:0] decoded_symbol;
  logic        symbol_valid;
  logic        symbol_ready;
  logic [15:0] mv_x;
  logic [15:0] mv_y;
  logic        mv_valid;
  logic        mv_ready;
  logic        start;
  logic        done;

  typedef struct {
    int          n;
    logic [63:0] syms;
    logic [15:0] ex;
    logic [15:0] ey;
    int          stall_at;
    int          hold;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] sb_q [$];
  int          n_vec;
  int          n_miss;

  av2_mv_decoder_real dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .context_idx    (context_idx),
    .context_prob   (context_prob),
    .decoded_symbol (decoded_symbol),
    .symbol_valid   (symbol_valid),
    .symbol_ready   (symbol_ready),
    .mv_x           (mv_x),
    .mv_y           (mv_y),
    .mv_valid       (mv_valid),
    .mv_ready       (mv_ready),
    .start          (start),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] bits(input string s);
    logic [63:0] b;
    b = 64'd0;
    for (int i = 0; i < s.len(); i++) begin
      b[i] = (s[i] == 8'h31);
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Present one symbol and hold it until it is consumed. Every symbol in
  // these flows is expected to find symbol_ready already high.
  task automatic send_sym(input logic s);
    int t;
    t = 0;
    @(negedge clk);
    symbol_valid   = 1'b1;
    decoded_symbol = {15'd0, s};
    chk("symbol_ready_on_time", 32'(symbol_ready), 32'd1);
    while (!symbol_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("symbol_ready_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    symbol_valid = 1'b0;
  endtask

  // Keep symbol_valid low for n cycles. A '1' stays on the bus, so a
  // spurious consume would change the magnitude.
  task automatic stall(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      symbol_valid   = 1'b0;
      decoded_symbol = 16'd1;
      chk("stall_symbol_ready", 32'(symbol_ready), 32'd1);
      chk("stall_mv_valid", 32'(mv_valid), 32'd0);
    end
  endtask

  // Compare the output pair against the scoreboard, apply back-pressure,
  // then run the handshake and check the done pulse.
  task automatic collect(input int hold);
    logic [31:0] exp;
    int          t;
    chk("mv_valid_after_last_symbol", 32'(mv_valid), 32'd1);
    t = 0;
    while (!mv_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_empty: actual 0 required 1");
    end else begin
      exp = sb_q.pop_front();
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        start = 1'b1;
        chk("hold_mv_valid", 32'(mv_valid), 32'd1);
        chk("hold_mv_x", 32'(mv_x), 32'(exp[31:16]));
        chk("hold_done", 32'(done), 32'd0);
      end
      start = 1'b0;
      chk("out_symbol_ready", 32'(symbol_ready), 32'd0);
      chk("mv_x", 32'(mv_x), 32'(exp[31:16]));
      chk("mv_y", 32'(mv_y), 32'(exp[15:0]));
      @(negedge clk);
      mv_ready = 1'b1;
      @(posedge clk);
      #1;
      mv_ready = 1'b0;
      chk("accept_mv_valid", 32'(mv_valid), 32'd0);
      chk("accept_done", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      chk("done_pulse_end", 32'(done), 32'd0);
      chk("mv_y_held", 32'(mv_y), 32'(exp[15:0]));
    end
  endtask

  task automatic run_vec(input vec_t v);
    sb_q.push_back({v.ex, v.ey});
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      if (i == v.stall_at) stall(5);
      send_sym(v.syms[i]);
    end
    collect(v.hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec          = 0;
    n_miss         = 0;
    rst_n          = 1'b1;
    context_idx    = 16'h1234;
    context_prob   = 16'h8000;
    decoded_symbol = 16'd0;
    symbol_valid   = 1'b0;
    mv_ready       = 1'b0;
    start          = 1'b0;

    //          n   symbols                                   x         y      stall hold
    vecs[0] = '{2,  bits("00"),                              16'h0000, 16'h0000, -1, 0};
    vecs[1] = '{11, bits("11111011110"),                     16'h0004, 16'h0003,  3, 0};
    vecs[2] = '{9,  bits("101110100"),                       16'hFFFC, 16'hFFFF, -1, 10};
    vecs[3] = '{4,  bits("0110"),                            16'h0000, 16'h0001, -1, 0};
    vecs[4] = '{20, bits("11111111111111111100"),            16'h0010, 16'hFFFF, -1, 0};
    vecs[5] = '{34, bits("1011111111111111110111111111111111"), 16'hFFF0, 16'hFFF0, -1, 0};
    vecs[6] = '{4,  bits("1000"),                            16'hFFFF, 16'h0000, -1, 0};

    #2 rst_n = 1'b0;
    #4;
    chk("reset_mv_x", 32'(mv_x), 32'd0);
    chk("reset_mv_y", 32'(mv_y), 32'd0);
    chk("reset_mv_valid", 32'(mv_valid), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_symbol_ready", 32'(symbol_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      run_vec(vecs[k]);
    end

    // Abort a pair while it is in Y_SIGN; x has already been decoded as 1.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_sym(1'b1);
    send_sym(1'b1);
    send_sym(1'b0);
    send_sym(1'b1);
    chk("pre_reset_mv_x", 32'(mv_x), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_mv_x", 32'(mv_x), 32'd0);
    chk("midrst_mv_y", 32'(mv_y), 32'd0);
    chk("midrst_mv_valid", 32'(mv_valid), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_symbol_ready", 32'(symbol_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[2]);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
